sram_controller: RTL
====================

Name: sram_controller

Overview:
- Sits directly upstream of the 16-bit off-chip SRAM.
- Sits between the ARM pipeline MEM stage and the SRAM bus: SRAM_DQ (16-bit), SRAM_ADDR (18-bit), SRAM_WE_N.
- Converts one 32-bit load/store request into two sequential 16-bit SRAM accesses, low half first.
- Holds ready low while busy so the pipeline freezes until the access completes.

Parameters:
- ACCESS_CYCLES, 3: clock cycles each 16-bit SRAM phase is held (covers SRAM read delay); legal range 1..15.
- DATA_BASE, 1024: byte address mapped to SRAM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  store request from MEM stage.
- rd_en  input  1  load request from MEM stage.
- address  input  32  byte address from ALU.
- writeData  input  32  store data.
- readData  output  32  load result, valid while ready=1 after a read.
- ready  output  1  0 = freeze pipeline; 1 = request done or idle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  SRAM write enable, active low.

Behaviour:
- Reset (async, immediate): state=IDLE, readData=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, phase counter=0.
- Address map: off = address - DATA_BASE (32-bit modular; below-base addresses wrap, no error). base = off[18:2]. Low half at {base,1'b0}, high half at {base,1'b1}. off[1:0] ignored.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE: wr_en=1 -> WR_LO; else rd_en=1 -> RD_LO; else stay. Write has priority when both are 1.
- Each LO/HI phase lasts exactly ACCESS_CYCLES cycles. The counter counts 0..ACCESS_CYCLES-1 and clears on phase exit.
- Phase order: LO then HI, then DONE.
- DONE lasts 1 cycle, then IDLE.
- WR_*: SRAM_WE_N=0. SRAM_DQ=writeData[15:0] in WR_LO, writeData[31:16] in WR_HI.
- All other states: SRAM_WE_N=1, SRAM_DQ=Z.
- RD_*: SRAM_DQ sampled on the rising edge ending the phase's last cycle. RD_LO -> readData[15:0]; RD_HI -> readData[31:16].
- readData holds its value until the next read completes; writes do not alter it.
- ready (combinational) = (IDLE && !wr_en && !rd_en) || DONE.
- Latency: ready low for 2*ACCESS_CYCLES+1 cycles from the request cycle. With ACCESS_CYCLES=3 that is 7 cycles, ready=1 on the 8th.
- The pipeline holds address/writeData/wr_en/rd_en stable while ready=0. The controller uses the live inputs every cycle and does not latch them.
- Back-to-back: the request in the cycle after DONE starts normally from IDLE.
- Reset mid-operation aborts the access immediately: the half written so far stays in SRAM, and partial readData is cleared to 0.

Optional Feature:
- Macro: SRAM_CTRL_STATS_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0]. Each increments once per completed read/write (on entering DONE), saturates at 16'hFFFF, and is cleared by rst.
- Undefined: these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package sram_ctrl_pkg: state encoding (3-bit enum IDLE..DONE), SRAM_DATA_W=16, SRAM_ADDR_W=18, default DATA_BASE.
- Sub-module sram_phase_counter: counter with clear and a terminal-count output at ACCESS_CYCLES-1; FSM advances on terminal count.

Test Plan:
- Write: wr_en=1, address=1024, writeData=32'hDEADBEEF -> SRAM mem[0]=16'hBEEF, mem[1]=16'hDEAD; SRAM_WE_N low 6 cycles; ready=0 for 7 cycles, then 1 for one cycle.
- Read back: rd_en=1, address=1024 after the write -> readData=32'hDEADBEEF at DONE; SRAM_ADDR 0 then 1; SRAM_DQ never driven by the controller.
- Address map: write 32'h12345678 at address=1032 -> mem[4]=16'h5678, mem[5]=16'h1234; address=1035 -> same locations.
- Priority: wr_en=1, rd_en=1, address=1028, writeData=32'hA5A5_5A5A -> write path taken (WE_N low); readData unchanged.
- Reset mid-access: assert rst during the WR_HI cycle 2 of a write of 32'hCAFEF00D to address 1040 -> immediately IDLE, WE_N=1, DQ=Z; mem[8]=16'hF00D, mem[9] unchanged.
- Back-to-back: write then read issued in the cycle after DONE -> second access starts that cycle; total 16 cycles for both; with SRAM_CTRL_STATS_EN defined, rd_count=1 and wr_count=1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the 32-bit-to-16-bit SRAM controller:
//   SRAM bus widths, default timing/address-map parameters, the FSM state
//   encoding and small state-decode helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int          SRAM_DATA_W           = 16;
  localparam int          SRAM_ADDR_W           = 18;
  localparam int          DEFAULT_ACCESS_CYCLES = 3;
  localparam logic [31:0] DEFAULT_DATA_BASE     = 32'd1024;

  // Wide enough for ACCESS_CYCLES up to 15.
  localparam int          PHASE_CNT_W           = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  // True in any state that is actively addressing the SRAM.
  function automatic logic is_access_state(input state_e s);
    return (s == WR_LO) || (s == WR_HI) || (s == RD_LO) || (s == RD_HI);
  endfunction

  // True while the upper 16 bits of the 32-bit word are being transferred.
  function automatic logic is_high_half(input state_e s);
    return (s == WR_HI) || (s == RD_HI);
  endfunction

endpackage : sram_ctrl_pkg

// File: rtl/sram_phase_counter.sv
// -----------------------------------------------------------------------------
// sram_phase_counter
//   Counts the cycles of one SRAM half-word phase. Counts 0..ACCESS_CYCLES-1
//   while enabled, wraps to 0 after the terminal count and clears whenever
//   clr_i is high.
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   asynchronous active-high reset
//     en_i   in   count enable (a phase is in progress)
//     clr_i  in   synchronous clear (no phase in progress)
//     tc_o   out  terminal count: current cycle is the last of the phase
// -----------------------------------------------------------------------------
module sram_phase_counter
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [PHASE_CNT_W-1:0] count_q;
  logic [PHASE_CNT_W-1:0] count_d;

  assign tc_o = (count_q == PHASE_CNT_W'(ACCESS_CYCLES - 1));

  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i || (en_i && tc_o)) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : sram_phase_counter

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM.
//   Each request becomes two SRAM accesses (low half-word, then high), each
//   held for ACCESS_CYCLES cycles, followed by a one-cycle DONE. ready is held
//   low for the whole access so the pipeline freezes. Request inputs are used
//   live every cycle; the pipeline keeps them stable while ready is low.
//
//   Parameters:
//     ACCESS_CYCLES  cycles per half-word phase (1..15)
//     DATA_BASE      byte address mapped to SRAM half-word 0
//
//   Ports:
//     clk        in     system clock, rising edge
//     rst        in     asynchronous active-high reset
//     wr_en      in     store request (wins over rd_en)
//     rd_en      in     load request
//     address    in     32-bit byte address
//     writeData  in     32-bit store data
//     readData   out    32-bit load result, held until the next read completes
//     ready      out    0 = freeze pipeline, 1 = idle or request done
//     SRAM_DQ    inout  16-bit SRAM data bus
//     SRAM_ADDR  out    18-bit SRAM half-word address
//     SRAM_WE_N  out    SRAM write enable, active low
//
//   Optional build macro SRAM_CTRL_STATS_EN adds:
//     rd_count   out    completed reads, saturating at 16'hFFFF
//     wr_count   out    completed writes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
  parameter logic [31:0] DATA_BASE     = DEFAULT_DATA_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  state_e      state_q;
  logic        we_n_q;
  logic [31:0] read_data_q;

  logic        in_phase;
  logic        high_half;
  logic        phase_tc;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign in_phase  = is_access_state(state_q);
  assign high_half = is_high_half(state_q);

  // ---------------------------------------------------------------------------
  // Phase timing
  // ---------------------------------------------------------------------------
  sram_phase_counter #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en_i  (in_phase),
    .clr_i (!in_phase),
    .tc_o  (phase_tc)
  );

  // ---------------------------------------------------------------------------
  // Address map: modular subtraction, so addresses below the base simply wrap.
  // Byte offset bits and bits above the SRAM range are dropped.
  // ---------------------------------------------------------------------------
  assign offset             = address - DATA_BASE;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  assign SRAM_ADDR = in_phase ? {offset[18:2], high_half} : '0;

  // ---------------------------------------------------------------------------
  // Main FSM with registered write strobe and read-data capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_n_q      <= 1'b1;
      read_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            state_q <= WR_LO;
            we_n_q  <= 1'b0;
          end else if (rd_en) begin
            state_q <= RD_LO;
          end
        end
        // Write strobe stays low across both halves; only the address and
        // data lanes change at the LO->HI boundary.
        WR_LO: begin
          if (phase_tc) begin
            state_q <= WR_HI;
          end
        end
        WR_HI: begin
          if (phase_tc) begin
            state_q <= DONE;
            we_n_q  <= 1'b1;
          end
        end
        // Read data is captured on the edge that ends the phase, giving the
        // SRAM the full ACCESS_CYCLES to settle.
        RD_LO: begin
          if (phase_tc) begin
            state_q           <= RD_HI;
            read_data_q[15:0] <= SRAM_DQ;
          end
        end
        RD_HI: begin
          if (phase_tc) begin
            state_q            <= DONE;
            read_data_q[31:16] <= SRAM_DQ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign SRAM_WE_N = we_n_q;

  // The bus is driven exactly when the write strobe is active, so the two can
  // never disagree.
  assign SRAM_DQ = !we_n_q ? (high_half ? writeData[31:16] : writeData[15:0])
                           : {SRAM_DATA_W{1'bz}};

  assign readData = read_data_q;

  // A new request in IDLE drops ready in the same cycle.
  assign ready = ((state_q == IDLE) && !wr_en && !rd_en) || (state_q == DONE);

`ifdef SRAM_CTRL_STATS_EN
  // ---------------------------------------------------------------------------
  // Completion counters: bump on the edge that enters DONE.
  // ---------------------------------------------------------------------------
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if ((state_q == RD_HI) && phase_tc && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if ((state_q == WR_HI) && phase_tc && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule : sram_controller
